// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the 3x3 convolution scan sequencer.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_CONV,
    ST_WAIT,
    ST_OUT,
    ST_FIN
  } state_t;

  localparam int KSIZE       = 3;
  localparam int NUM_TAPS    = KSIZE * KSIZE;
  localparam int FETCH_FULL  = NUM_TAPS;  // pixels fetched for a fresh window
  localparam int FETCH_REUSE = KSIZE;     // pixels fetched when sliding one column

  localparam logic [1:0] K_LAST = 2'(KSIZE - 1);

  // First window column to fetch: skip the columns already held in the
  // window register when sliding.
  function automatic logic [1:0] first_col(input logic reuse);
    return reuse ? 2'(KSIZE - FETCH_REUSE / KSIZE) : 2'(KSIZE - FETCH_FULL / KSIZE);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window position and fetch counters; produces the BRAM read address.
// Build option: CONV_WINDOW_REUSE_EN -- when defined, a window that slides
// right within a row fetches only its new rightmost column.
module conv_addr_gen
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128,
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 0,
  parameter int XY_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              step,
  input  logic              advance,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              fetch_valid,
  output logic              last_fetch,
  output logic [XY_W-1:0]   x,
  output logic [XY_W-1:0]   y,
  output logic              last_window
);

`ifdef CONV_WINDOW_REUSE_EN
  localparam logic REUSE = 1'b1;
`else
  localparam logic REUSE = 1'b0;
`endif

  logic [1:0]        c;
  logic [1:0]        r;
  logic [ADDR_W-1:0] addr_cur;
  logic [ADDR_W-1:0] addr_hold;
  logic              last_col;

  // Address of pixel (x+c, y+r), truncated to the BRAM address width.
  assign addr_cur = ADDR_W'(BASE_ADDR)
                  + (ADDR_W'(y) + ADDR_W'(r)) * ADDR_W'(IMG_W)
                  + ADDR_W'(x) + ADDR_W'(c);

  assign last_col    = (x == XY_W'(IMG_W - 3));
  assign last_window = last_col && (y == XY_W'(IMG_H - 3));
  assign fetch_valid = step;
  assign last_fetch  = step && (c == K_LAST) && (r == K_LAST);
  // The address is live while fetching and frozen at the last issued one otherwise.
  assign bram_addr   = step ? addr_cur : addr_hold;

  // Window position and column-major fetch counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      x         <= '0;
      y         <= '0;
      c         <= '0;
      r         <= '0;
      addr_hold <= '0;
    end else if (init) begin
      x <= '0;
      y <= '0;
      c <= first_col(1'b0);
      r <= '0;
    end else if (advance) begin
      r <= '0;
      if (last_col) begin
        x <= '0;
        y <= y + XY_W'(1);
        c <= first_col(1'b0);
      end else begin
        x <= x + XY_W'(1);
        c <= first_col(REUSE);
      end
    end else if (step) begin
      addr_hold <= addr_cur;
      if (r == K_LAST) begin
        r <= '0;
        c <= c + 2'd1;
      end else begin
        r <= r + 2'd1;
      end
    end
  end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Scans a 3x3 window across the image, feeds the convolver and streams
// one result per window over a valid/ready interface.
// Build option: CONV_WINDOW_REUSE_EN (see conv_addr_gen) changes fetch
// timing only; results are identical.
module conv_scan_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128,
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 0,
  parameter int RES_W     = 20,
  parameter int XY_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              shift_right,
  output logic              start_conv,
  input  logic              done_conv,
  input  logic [RES_W-1:0]  conv_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic [XY_W-1:0]   out_x,
  output logic [XY_W-1:0]   out_y
);

  state_t          state_q, state_d;
  logic            init, step, advance, capture;
  logic            fetch_valid, last_fetch, last_window;
  logic [XY_W-1:0] x, y;

  conv_addr_gen #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .XY_W      (XY_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .init        (init),
    .step        (step),
    .advance     (advance),
    .bram_addr   (bram_addr),
    .fetch_valid (fetch_valid),
    .last_fetch  (last_fetch),
    .x           (x),
    .y           (y),
    .last_window (last_window)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and counter controls.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d = state_q;
    init    = 1'b0;
    step    = 1'b0;
    advance = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          init    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        step = 1'b1;
        if (last_fetch) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_CONV;
      ST_CONV:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_conv) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          advance = 1'b1;
          state_d = last_window ? ST_FIN : ST_FETCH;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign start_conv = (state_q == ST_CONV);
  assign out_valid  = (state_q == ST_OUT);
  assign done       = (state_q == ST_FIN);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);

  // Shift strobe lags each fetch by the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) shift_right <= 1'b0;
    else     shift_right <= fetch_valid;
  end

  // Result capture; held until the consumer accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_x    <= '0;
      out_y    <= '0;
    end else if (capture) begin
      out_data <= conv_result;
      out_x    <= x;
      out_y    <= y;
    end
  end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Self-checking bench for conv_scan_ctrl: BRAM, window register and
// convolver models around the DUT, a reference built straight from the
// image, randomized pixels, latency and backpressure.
module tb_conv_scan_ctrl;

  localparam int IMG_W     = 6;
  localparam int IMG_H     = 4;
  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 5;
  localparam int RES_W     = 20;
  localparam int XY_W      = 4;
  localparam int NX        = IMG_W - 2;
  localparam int NY        = IMG_H - 2;
  localparam int TIMEOUT   = 5000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, shift_right, start_conv, out_valid;
  logic [ADDR_W-1:0] bram_addr;
  logic              done_conv = 1'b0;
  logic [RES_W-1:0]  conv_result = '0;
  logic              out_ready = 1'b0;
  logic [RES_W-1:0]  out_data;
  logic [XY_W-1:0]   out_x, out_y;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int               x;
    int               y;
    logic [RES_W-1:0] data;
  } res_t;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] douta;
  logic [7:0] win [0:8];

  int   exp_addr[$];
  res_t exp_res[$];
  int   n_fetch_exp;
  bit   mon_en = 1'b0;
  bit   spurious_en = 1'b0;
  int   done_cnt, result_cnt, shift_cnt, stall_left;

  always #5 clk = ~clk;

  conv_scan_ctrl #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .RES_W     (RES_W),
    .XY_W      (XY_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .bram_addr   (bram_addr),
    .shift_right (shift_right),
    .start_conv  (start_conv),
    .done_conv   (done_conv),
    .conv_result (conv_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_x       (out_x),
    .out_y       (out_y)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Single-port BRAM with one cycle of read latency.
  always @(posedge clk) douta <= mem[bram_addr];

  // 72-bit window shift register: oldest pixel in win[0].
  always @(posedge clk) begin
    if (shift_right) begin
      for (int i = 0; i < 8; i++) win[i] <= win[i+1];
      win[8] <= douta;
    end
  end

  // Reference result of window (x,y): taps weighted 1..9 in column-major order.
  function automatic logic [RES_W-1:0] ref_result(input int wx, input int wy);
    int sum = 0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        sum += int'(mem[BASE_ADDR + (wy + r) * IMG_W + wx + c]) * (c * 3 + r + 1);
    return RES_W'(sum);
  endfunction

  // Convolver model: same weighting applied to the window register, random
  // latency, optional spurious completion pulses while fetching.
  initial begin
    int               cnt = -1;
    logic [RES_W-1:0] pend;
    forever @(posedge clk) begin
      int sum;
      #1;
      done_conv   = 1'b0;
      conv_result = RES_W'($urandom);
      if (rst) begin
        cnt = -1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done_conv   = 1'b1;
          conv_result = pend;
          cnt         = -1;
        end
      end else if (start_conv) begin
        sum = 0;
        for (int i = 0; i < 9; i++) sum += int'(win[i]) * (i + 1);
        pend = RES_W'(sum);
        cnt  = $urandom_range(1, 4);
      end else if (spurious_en && shift_right && ($urandom_range(0, 2) == 0)) begin
        done_conv = 1'b1;
      end
    end
  end

  // Monitor and consumer: samples on the falling edge, then picks out_ready.
  initial begin
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [RES_W-1:0]  prev_data = '0;
    logic [XY_W-1:0]   prev_x = '0, prev_y = '0;
    logic              prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
    res_t              e;
    forever @(negedge clk) begin
      if (mon_en) begin
        if (shift_right) begin
          shift_cnt++;
          if (exp_addr.size() == 0) check("addr_extra", 32'd1, 32'd0);
          else check("bram_addr", 32'(prev_addr), 32'(exp_addr.pop_front()));
        end
        if (out_valid) begin
          if (prev_valid && !prev_ready) begin
            check("hold_data", 32'(out_data), 32'(prev_data));
            check("hold_x", 32'(out_x), 32'(prev_x));
            check("hold_y", 32'(out_y), 32'(prev_y));
            check("hold_addr", 32'(bram_addr), 32'(prev_addr));
            check("hold_shift", 32'(shift_right), 32'd0);
            check("hold_start_conv", 32'(start_conv), 32'd0);
          end else if (exp_res.size() == 0) begin
            check("res_extra", 32'd1, 32'd0);
          end else begin
            e = exp_res.pop_front();
            result_cnt++;
            check("res_data", 32'(out_data), 32'(e.data));
            check("res_x", 32'(out_x), 32'(e.x));
            check("res_y", 32'(out_y), 32'(e.y));
          end
        end
        if (done) begin
          done_cnt++;
          check("done_width", 32'(prev_done), 32'd0);
          check("busy_at_done", 32'(busy), 32'd0);
        end
        if (out_valid && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end else begin
        out_ready = 1'b0;
      end
      prev_addr  = bram_addr;
      prev_data  = out_data;
      prev_x     = out_x;
      prev_y     = out_y;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_done  = done;
    end
  end

  // Expected fetch addresses and results for one full pass, from the image rules.
  task automatic build_expect();
    bit reuse;
`ifdef CONV_WINDOW_REUSE_EN
    reuse = 1'b1;
`else
    reuse = 1'b0;
`endif
    exp_addr.delete();
    exp_res.delete();
    for (int wy = 0; wy < NY; wy++) begin
      for (int wx = 0; wx < NX; wx++) begin
        res_t e;
        int   cfirst = (reuse && wx > 0) ? 2 : 0;
        for (int c = cfirst; c < 3; c++)
          for (int r = 0; r < 3; r++)
            exp_addr.push_back((BASE_ADDR + (wy + r) * IMG_W + wx + c) % (1 << ADDR_W));
        e.x    = wx;
        e.y    = wy;
        e.data = ref_result(wx, wy);
        exp_res.push_back(e);
      end
    end
    n_fetch_exp = exp_addr.size();
  endtask

  task automatic fill_image();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
  endtask

  task automatic check_outputs_zero();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bram_addr", 32'(bram_addr), 32'd0);
    check("rst_shift_right", 32'(shift_right), 32'd0);
    check("rst_start_conv", 32'(start_conv), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_x", 32'(out_x), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
  endtask

  // One image pass; optionally pulses start again while busy.
  task automatic run_pass(input bit inject_start);
    int cyc = 0;
    build_expect();
    done_cnt   = 0;
    result_cnt = 0;
    shift_cnt  = 0;
    stall_left = 5;
    mon_en     = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (done_cnt == 0 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      start = (inject_start && (cyc == 30 || cyc == 75));
    end
    start = 1'b0;
    check("pass_timeout", 32'(cyc < TIMEOUT), 32'd1);
    repeat (4) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'd1);
    check("result_count", 32'(result_cnt), 32'(NX * NY));
    check("shift_count", 32'(shift_cnt), 32'(n_fetch_exp));
    check("addr_left", 32'(exp_addr.size()), 32'd0);
    check("res_left", 32'(exp_res.size()), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    mon_en = 1'b0;
  endtask

  // Start a pass, then reset it part-way through the first window's fetch.
  task automatic reset_mid_fetch();
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("fetch_active", 32'(shift_right), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero();
    repeat (3) @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'd0);
  endtask

  initial begin
    fill_image();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero();
    rst = 1'b0;
    @(negedge clk);

    spurious_en = 1'b1;
    run_pass(1'b1);

    reset_mid_fetch();

    spurious_en = 1'b0;
    fill_image();
    run_pass(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
